// File: rtl/frame_pkg.sv
// Shared frame IDs, scheduler state type and ID classification helpers.
package frame_pkg;

  localparam int ID_WIDTH = 16;
  localparam logic [ID_WIDTH-1:0] HEADER_ID       = 16'hAAAA;
  localparam logic [ID_WIDTH-1:0] FOOTER_ID       = 16'h5555;
  localparam logic [ID_WIDTH-1:0] ERROR_HEADER_ID = 16'hAAEE;
  localparam logic [ID_WIDTH-1:0] ERROR_FOOTER_ID = 16'h55EE;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } sched_state_t;

  // Repaired IDs count as valid so a word that was already patched upstream is not re-flagged.
  function automatic logic is_header(input logic [ID_WIDTH-1:0] word_hi);
    return (word_hi == HEADER_ID) || (word_hi == ERROR_HEADER_ID);
  endfunction

  function automatic logic is_footer(input logic [ID_WIDTH-1:0] word_lo);
    return (word_lo == FOOTER_ID) || (word_lo == ERROR_FOOTER_ID);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester after last_ch, wrapping modulo CH_NUM.
module rr_select #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_W-1:0]   last_ch,
  output logic              found,
  output logic [CH_W-1:0]   ch
);

  logic [CH_W-1:0] idx;

  always_comb begin
    found = 1'b0;
    ch    = '0;
    idx   = '0;
    // Offset CH_NUM revisits last_ch itself, so a lone requester is re-granted.
    for (int off = 1; off <= CH_NUM; off++) begin
      idx = CH_W'((int'(last_ch) + off) % CH_NUM);
      if (!found && req[idx]) begin
        found = 1'b1;
        ch    = idx;
      end
    end
  end

endmodule

// File: rtl/frame_rr_scheduler.sv
// Frame-granular round-robin scheduler with on-the-fly header/footer repair.
// Optional per-channel statistics ports under FRAME_RR_SCHEDULER_STATS_EN.
module frame_rr_scheduler
  import frame_pkg::*;
#(
  parameter int CH_NUM        = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_FRAME_LEN = 256
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CH_NUM-1:0]            READ_REQUEST,
  input  logic [CH_NUM*DATA_WIDTH-1:0] DIN,
  output logic [CH_NUM-1:0]            RE,
  input  logic                         iREADY,
  output logic [DATA_WIDTH-1:0]        DOUT,
  output logic                         oVALID,
  output logic [$clog2(CH_NUM)-1:0]    GRANT_CH,
  output logic                         BUSY,
  output logic                         FRAME_ERROR
`ifdef FRAME_RR_SCHEDULER_STATS_EN
  ,
  output logic [CH_NUM*32-1:0]         FRAME_CNT,
  output logic [CH_NUM*16-1:0]         ERR_CNT
`endif
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int CNT_W = $clog2(MAX_FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(MAX_FRAME_LEN - 1);
  localparam logic [DATA_WIDTH-1:0] DOUT_RST = {(DATA_WIDTH/4){4'hE}};

  sched_state_t          state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       last_ch_q, last_ch_d;
  logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ovalid_q, ovalid_d;
  logic                  ferr_q, ferr_d;

  logic [DATA_WIDTH-1:0] din_arr [CH_NUM];
  logic [DATA_WIDTH-1:0] din_g;
  logic                  req_g, in_read, hdr_in, ftr_in;
  logic                  mid_hdr, accept, hdr_fix, len_over, frame_end, emit_fix;
  logic                  sel_found;
  logic [CH_W-1:0]       sel_ch;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_din
      assign din_arr[gi] = DIN[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  rr_select #(
    .CH_NUM (CH_NUM),
    .CH_W   (CH_W)
  ) u_rr_select (
    .req     (READ_REQUEST),
    .last_ch (last_ch_q),
    .found   (sel_found),
    .ch      (sel_ch)
  );

  assign din_g   = din_arr[grant_q];
  assign req_g   = READ_REQUEST[grant_q];
  assign in_read = (state_q == ST_READ);
  assign hdr_in  = is_header(din_g[DATA_WIDTH-1 -: ID_WIDTH]);
  assign ftr_in  = is_footer(din_g[ID_WIDTH-1:0]);

  // A header mid-frame means the footer was lost; the header stays queued for the next grant.
  assign mid_hdr   = in_read & req_g & hdr_in & (word_cnt_q != '0);
  // Reset gates the read so an abandoned frame never pops a word it cannot forward.
  assign accept    = in_read & iREADY & req_g & ~mid_hdr & ~RESET;
  assign hdr_fix   = accept & (word_cnt_q == '0) & ~hdr_in;
  assign len_over  = accept & ~ftr_in & (word_cnt_q == LAST_CNT);
  assign frame_end = accept & (ftr_in | len_over);
  assign emit_fix  = mid_hdr & iREADY;

  always_comb begin
    RE          = '0;
    RE[grant_q] = accept;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ch_d  = last_ch_q;
    word_cnt_d = word_cnt_q;
    dout_d     = dout_q;
    ovalid_d   = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found && iREADY) begin
          grant_d    = sel_ch;
          last_ch_d  = sel_ch;
          word_cnt_d = '0;
          state_d    = ST_READ;
        end
      end
      ST_READ: begin
        if (emit_fix) begin
          dout_d   = {{(DATA_WIDTH-ID_WIDTH){1'b0}}, ERROR_FOOTER_ID};
          ovalid_d = 1'b1;
          ferr_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (accept) begin
          dout_d = din_g;
          if (hdr_fix) dout_d[DATA_WIDTH-1 -: ID_WIDTH] = ERROR_HEADER_ID;
          if (len_over) dout_d[ID_WIDTH-1:0] = ERROR_FOOTER_ID;
          ovalid_d   = 1'b1;
          ferr_d     = hdr_fix | len_over;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (frame_end) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_ch_q  <= CH_W'(CH_NUM - 1);
      word_cnt_q <= '0;
      dout_q     <= DOUT_RST;
      ovalid_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ch_q  <= last_ch_d;
      word_cnt_q <= word_cnt_d;
      dout_q     <= dout_d;
      ovalid_q   <= ovalid_d;
      ferr_q     <= ferr_d;
    end
  end

  assign DOUT        = dout_q;
  assign oVALID      = ovalid_q;
  assign GRANT_CH    = grant_q;
  assign BUSY        = in_read;
  assign FRAME_ERROR = ferr_q;

`ifdef FRAME_RR_SCHEDULER_STATS_EN
  logic stat_done, stat_err;
  assign stat_done = frame_end | emit_fix;
  assign stat_err  = hdr_fix | len_over | emit_fix;

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_stats
      logic [31:0] frame_cnt_q, frame_cnt_d;
      logic [15:0] err_cnt_q, err_cnt_d;
      logic        ch_sel;

      assign ch_sel = (grant_q == CH_W'(gi));

      always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (ch_sel && stat_done && (frame_cnt_q != '1)) frame_cnt_d = frame_cnt_q + 32'd1;
        if (ch_sel && stat_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
      end

      always_ff @(posedge CLK) begin
        if (RESET) begin
          frame_cnt_q <= '0;
          err_cnt_q   <= '0;
        end else begin
          frame_cnt_q <= frame_cnt_d;
          err_cnt_q   <= err_cnt_d;
        end
      end

      assign FRAME_CNT[gi*32 +: 32] = frame_cnt_q;
      assign ERR_CNT[gi*16 +: 16]   = err_cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Directed bench for frame_rr_scheduler: FWFT FIFO models per channel, scenario tasks with inline checks.
module tb_frame_rr_scheduler;

  localparam int CH_NUM = 4;
  localparam int DW     = 64;
  localparam int MFL    = 4;
  localparam logic [63:0] DOUT_RST = 64'hEEEE_EEEE_EEEE_EEEE;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [CH_NUM-1:0] READ_REQUEST;
  logic [CH_NUM*DW-1:0] DIN;
  logic [CH_NUM-1:0] RE;
  logic              iREADY = 1'b1;
  logic [DW-1:0]     DOUT;
  logic              oVALID;
  logic [1:0]        GRANT_CH;
  logic              BUSY;
  logic              FRAME_ERROR;
`ifdef FRAME_RR_SCHEDULER_STATS_EN
  logic [CH_NUM*32-1:0] FRAME_CNT;
  logic [CH_NUM*16-1:0] ERR_CNT;
`endif

  frame_rr_scheduler #(
    .CH_NUM        (CH_NUM),
    .DATA_WIDTH    (DW),
    .MAX_FRAME_LEN (MFL)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ_REQUEST (READ_REQUEST),
    .DIN          (DIN),
    .RE           (RE),
    .iREADY       (iREADY),
    .DOUT         (DOUT),
    .oVALID       (oVALID),
    .GRANT_CH     (GRANT_CH),
    .BUSY         (BUSY),
    .FRAME_ERROR  (FRAME_ERROR)
`ifdef FRAME_RR_SCHEDULER_STATS_EN
    ,
    .FRAME_CNT    (FRAME_CNT),
    .ERR_CNT      (ERR_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  logic [63:0] fifo_q [CH_NUM][$];
  logic [63:0] out_log [$];
  logic [CH_NUM-1:0] re_pre;
  int err_pulses = 0;
  int cycles = 0;
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [63:0] hdr(input int ch, input int n);
    return {16'hAAAA, 8'(ch), 8'(n), 32'h0000_0000};
  endfunction
  function automatic logic [63:0] mid(input int ch, input int n);
    return {16'h1111, 8'(ch), 8'(n), 32'h0000_0001};
  endfunction
  function automatic logic [63:0] ftr(input int ch, input int n);
    return {16'h2222, 8'(ch), 8'(n), 16'h0000, 16'h5555};
  endfunction

  task automatic drive();
    for (int i = 0; i < CH_NUM; i++) begin
      READ_REQUEST[i] = (fifo_q[i].size() != 0);
      DIN[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : 64'h0;
    end
  endtask

  task automatic push(input int ch, input logic [63:0] w);
    fifo_q[ch].push_back(w);
    drive();
  endtask

  // One clock: capture settled RE, pop read FIFOs on the edge, then sample outputs.
  task automatic step();
    #1;
    re_pre = RE;
    @(posedge CLK);
    for (int i = 0; i < CH_NUM; i++)
      if (re_pre[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
    #1;
    drive();
    #1;
    cycles++;
    if (oVALID) begin
      out_log.push_back(DOUT);
      $display("[%0t] word ch%0d %h ferr=%0b", $time, GRANT_CH, DOUT, FRAME_ERROR);
    end
    if (FRAME_ERROR) err_pulses++;
  endtask

  task automatic run_until(input int n, input int bound, output bit timed_out);
    int k = 0;
    while (out_log.size() < n && k < bound) begin
      step();
      k++;
    end
    timed_out = (out_log.size() < n);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    n_cmp++; if (DOUT !== DOUT_RST) begin n_err++; $display("FAIL reset_dout: got %h expected %h", DOUT, DOUT_RST); end
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b expected 0", oVALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_cmp++; if (FRAME_ERROR !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", FRAME_ERROR); end
    n_cmp++; if (GRANT_CH !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d expected 0", GRANT_CH); end
    n_cmp++; if (RE !== 4'b0) begin n_err++; $display("FAIL reset_re: got %b expected 0000", RE); end
    RESET = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_q [$];
    int e0, c0;
    bit to;
    out_log.delete();
    e0 = err_pulses;
    c0 = cycles;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 4; c += 2) begin
        push(c, hdr(c, n)); push(c, mid(c, n)); push(c, ftr(c, n));
        exp_q.push_back(hdr(c, n)); exp_q.push_back(mid(c, n)); exp_q.push_back(ftr(c, n));
      end
    end
    run_until(12, 40, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rr_timeout: got %0d words expected 12", out_log.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_q[k]) begin n_err++; $display("FAIL rr_word%0d: got %h expected %h", k, out_log[k], exp_q[k]); end
    end
    n_cmp++; if (cycles - c0 != 16) begin n_err++; $display("FAIL rr_cycles: got %0d expected 16", cycles - c0); end
    n_cmp++; if (err_pulses != e0) begin n_err++; $display("FAIL rr_ferr: got %0d pulses expected 0", err_pulses - e0); end
    n_cmp++; if (fifo_q[0].size() + fifo_q[2].size() != 0) begin n_err++; $display("FAIL rr_drain: got %0d left expected 0", fifo_q[0].size() + fifo_q[2].size()); end
  endtask

  task automatic test_back_pressure();
    logic [63:0] exp_q [$];
    bit to;
    out_log.delete();
    push(1, hdr(1, 5)); push(1, mid(1, 5)); push(1, ftr(1, 5));
    exp_q.push_back(hdr(1, 5)); exp_q.push_back(mid(1, 5)); exp_q.push_back(ftr(1, 5));
    step();
    step();
    iREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++; if (re_pre !== 4'b0) begin n_err++; $display("FAIL bp_re%0d: got %b expected 0000", k, re_pre); end
      n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL bp_ovalid%0d: got %b expected 0", k, oVALID); end
    end
    n_cmp++; if (DOUT !== hdr(1, 5)) begin n_err++; $display("FAIL bp_hold: got %h expected %h", DOUT, hdr(1, 5)); end
    iREADY = 1'b1;
    run_until(3, 10, to);
    n_cmp++; if (to || out_log.size() != 3) begin n_err++; $display("FAIL bp_count: got %0d words expected 3", out_log.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_word%0d: got %h expected %h", k, out_log[k], exp_q[k]); end
    end
  endtask

  task automatic test_lost_footer();
    logic [63:0] exp_q [$];
    int e0;
    bit to;
    out_log.delete();
    e0 = err_pulses;
    push(3, hdr(3, 1)); push(3, mid(3, 1));
    push(3, hdr(3, 2)); push(3, mid(3, 2)); push(3, ftr(3, 2));
    exp_q.push_back(hdr(3, 1)); exp_q.push_back(mid(3, 1)); exp_q.push_back(64'h0000_0000_0000_55EE);
    exp_q.push_back(hdr(3, 2)); exp_q.push_back(mid(3, 2)); exp_q.push_back(ftr(3, 2));
    run_until(6, 20, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL lf_timeout: got %0d words expected 6", out_log.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_q[k]) begin n_err++; $display("FAIL lf_word%0d: got %h expected %h", k, out_log[k], exp_q[k]); end
    end
    n_cmp++; if (err_pulses - e0 != 1) begin n_err++; $display("FAIL lf_ferr: got %0d pulses expected 1", err_pulses - e0); end
  endtask

  task automatic test_missing_header();
    logic [63:0] exp_q [$];
    int e0;
    bit to;
    out_log.delete();
    e0 = err_pulses;
    push(0, 64'h1234_5678_9ABC_0000); push(0, ftr(0, 7)); push(0, 64'h1234_0000_0000_5555);
    exp_q.push_back(64'hAAEE_5678_9ABC_0000); exp_q.push_back(ftr(0, 7)); exp_q.push_back(64'hAAEE_0000_0000_5555);
    run_until(3, 20, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL mh_timeout: got %0d words expected 3", out_log.size()); end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_q[k]) begin n_err++; $display("FAIL mh_word%0d: got %h expected %h", k, out_log[k], exp_q[k]); end
    end
    n_cmp++; if (err_pulses - e0 != 2) begin n_err++; $display("FAIL mh_ferr: got %0d pulses expected 2", err_pulses - e0); end
  endtask

  task automatic test_length_overflow();
    logic [63:0] exp_q [$];
    logic [63:0] w;
    int e0;
    bit to;
    out_log.delete();
    e0 = err_pulses;
    push(1, hdr(1, 9));
    for (int k = 1; k <= 5; k++) push(1, mid(1, k));
    push(2, hdr(2, 9)); push(2, ftr(2, 9));
    exp_q.push_back(hdr(1, 9)); exp_q.push_back(mid(1, 1)); exp_q.push_back(mid(1, 2));
    w = mid(1, 3); w[15:0] = 16'h55EE; exp_q.push_back(w);
    exp_q.push_back(hdr(2, 9)); exp_q.push_back(ftr(2, 9));
    w = mid(1, 4); w[63:48] = 16'hAAEE; exp_q.push_back(w);
    exp_q.push_back(mid(1, 5)); exp_q.push_back(ftr(1, 9));
    run_until(8, 30, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL lo_timeout: got %0d words expected 8", out_log.size()); end
    step();
    step();
    n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL lo_bubble_busy: got %b expected 1", BUSY); end
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL lo_bubble_ovalid: got %b expected 0", oVALID); end
    push(1, ftr(1, 9));
    run_until(9, 10, to);
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (out_log[k] !== exp_q[k]) begin n_err++; $display("FAIL lo_word%0d: got %h expected %h", k, out_log[k], exp_q[k]); end
    end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL lo_end_busy: got %b expected 0", BUSY); end
    n_cmp++; if (err_pulses - e0 != 2) begin n_err++; $display("FAIL lo_ferr: got %0d pulses expected 2", err_pulses - e0); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    out_log.delete();
    push(2, hdr(2, 3)); push(2, mid(2, 3)); push(2, ftr(2, 3));
    push(0, hdr(0, 3)); push(0, ftr(0, 3));
    step();
    step();
    n_cmp++; if (GRANT_CH !== 2'd2) begin n_err++; $display("FAIL rm_grant_pre: got %0d expected 2", GRANT_CH); end
    RESET = 1'b1;
    step();
    n_cmp++; if (re_pre !== 4'b0) begin n_err++; $display("FAIL rm_re_in_reset: got %b expected 0000", re_pre); end
    n_cmp++; if (oVALID !== 1'b0) begin n_err++; $display("FAIL rm_ovalid: got %b expected 0", oVALID); end
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b expected 0", BUSY); end
    n_cmp++; if (RE !== 4'b0) begin n_err++; $display("FAIL rm_re: got %b expected 0000", RE); end
    n_cmp++; if (fifo_q[2].size() != 2) begin n_err++; $display("FAIL rm_fifo_kept: got %0d expected 2", fifo_q[2].size()); end
    RESET = 1'b0;
    out_log.delete();
    step();
    n_cmp++; if (GRANT_CH !== 2'd0) begin n_err++; $display("FAIL rm_grant_post: got %0d expected 0", GRANT_CH); end
    run_until(2, 10, to);
    n_cmp++; if (out_log[0] !== hdr(0, 3)) begin n_err++; $display("FAIL rm_word0: got %h expected %h", out_log[0], hdr(0, 3)); end
    n_cmp++; if (out_log[1] !== ftr(0, 3)) begin n_err++; $display("FAIL rm_word1: got %h expected %h", out_log[1], ftr(0, 3)); end
  endtask

  initial begin
    drive();
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_lost_footer();
    test_missing_header();
    test_length_overflow();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
